// File: rtl/regfile_write_arbiter_if.sv
// Shared types and the requester/register-file bundle for the write-port arbiter.
// The slave side belongs to the arbiter; the master side to whatever drives it.
package cpu_types_pkg;
    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic     valid;
        regbits_t wsel;
        word_t    wdat;
    } wreq_t;
endpackage

interface regfile_write_arbiter_if;
    import cpu_types_pkg::*;

    logic     halt;
    logic     req0_valid;
    regbits_t req0_wsel;
    word_t    req0_wdat;
    logic     req0_ready;
    logic     req1_valid;
    regbits_t req1_wsel;
    word_t    req1_wdat;
    logic     req1_ready;
    logic     WEN;
    regbits_t wsel;
    word_t    wdat;
    regbits_t rsel1;
    regbits_t rsel2;
    logic     haz1;
    logic     haz2;
    logic     last_grant;

    modport master (
        output halt, req0_valid, req0_wsel, req0_wdat, req1_valid, req1_wsel, req1_wdat,
        output rsel1, rsel2,
        input  req0_ready, req1_ready, WEN, wsel, wdat, haz1, haz2, last_grant
    );

    modport slave (
        input  halt, req0_valid, req0_wsel, req0_wdat, req1_valid, req1_wsel, req1_wdat,
        input  rsel1, rsel2,
        output req0_ready, req1_ready, WEN, wsel, wdat, haz1, haz2, last_grant
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between two write-back
// requesters, with a one-entry write stage and read-after-write hazard flags.
module regfile_write_arbiter
    import cpu_types_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST,
    regfile_write_arbiter_if.slave   bus
);
    wreq_t [1:0] req;
    logic  [1:0] gnt;
    logic        xfer;
    logic        gid;
    wreq_t       win;

    logic        prio;
    logic        last_q;
    logic        wen_q;
    regbits_t    wsel_q;
    word_t       wdat_q;

    assign req[0] = '{valid: bus.req0_valid, wsel: bus.req0_wsel, wdat: bus.req0_wdat};
    assign req[1] = '{valid: bus.req1_valid, wsel: bus.req1_wsel, wdat: bus.req1_wdat};

    // Grants depend only on valids, prio, halt and reset, never on ready.
    always_comb begin
        gnt = 2'b00;
        if (!RST && !bus.halt) begin
            if (req[0].valid && req[1].valid)
                gnt = prio ? 2'b10 : 2'b01;
            else
                gnt = {req[1].valid, req[0].valid};
        end
    end

    assign xfer = |gnt;
    assign gid  = gnt[1];
    assign win  = req[gid];

    always_ff @(posedge CLK) begin
        if (RST) begin
            prio   <= 1'b0;
            last_q <= 1'b0;
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
        end else begin
            wen_q <= 1'b0;
            if (xfer) begin
                prio   <= ~gid;
                last_q <= gid;
                wsel_q <= win.wsel;
                wdat_q <= win.wdat;
                // $zero writes are consumed but never reach the register file.
                wen_q  <= (win.wsel != '0);
            end
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.WEN        = wen_q;
    assign bus.wsel       = wsel_q;
    assign bus.wdat       = wdat_q;
    assign bus.last_grant = last_q;
    assign bus.haz1       = wen_q && (wsel_q == bus.rsel1);
    assign bus.haz2       = wen_q && (wsel_q == bus.rsel2);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a per-cycle reference model plus
// hand-computed checkpoints for reset, single, contention, $zero, hazard and halt.
module tb_regfile_write_arbiter;
    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: state after each edge, derived from the arbitration rules.
    int          m_prio = 0;
    int          m_last = 0;
    bit          m_wen  = 0;
    logic [4:0]  m_wsel = '0;
    logic [31:0] m_wdat = '0;

    initial begin
        @(posedge CLK);
        forever begin
            int win;
            @(negedge CLK);
            win = -1;
            if (!RST && !bus.halt) begin
                if (bus.req0_valid && bus.req1_valid) win = m_prio;
                else if (bus.req0_valid)              win = 0;
                else if (bus.req1_valid)              win = 1;
            end
            chk("m_ready0", bus.req0_ready, (win == 0));
            chk("m_ready1", bus.req1_ready, (win == 1));
            chk("m_wen",    bus.WEN,  m_wen);
            chk("m_wsel",   bus.wsel, m_wsel);
            chk("m_wdat",   bus.wdat, m_wdat);
            chk("m_last",   bus.last_grant, m_last);
            chk("m_haz1",   bus.haz1, m_wen && (m_wsel == bus.rsel1));
            chk("m_haz2",   bus.haz2, m_wen && (m_wsel == bus.rsel2));
            if (RST) begin
                m_prio = 0; m_last = 0; m_wen = 0; m_wsel = '0; m_wdat = '0;
            end else if (win >= 0) begin
                m_prio = 1 - win;
                m_last = win;
                m_wsel = (win == 0) ? bus.req0_wsel : bus.req1_wsel;
                m_wdat = (win == 0) ? bus.req0_wdat : bus.req1_wdat;
                m_wen  = (m_wsel != 0);
            end else begin
                m_wen = 0;
            end
        end
    end

    initial begin
        logic [31:0] prev;
        RST = 1'b1;
        bus.halt = 0; bus.rsel1 = 5'd31; bus.rsel2 = 5'd30;
        bus.req0_valid = 1; bus.req0_wsel = 5'd1; bus.req0_wdat = 32'h1111_0001;
        bus.req1_valid = 1; bus.req1_wsel = 5'd2; bus.req1_wdat = 32'h2222_0002;

        // Reset held two cycles with both requesters valid.
        step();
        step();
        @(negedge CLK);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_wen",    bus.WEN, 0);
        chk("rst_wsel",   bus.wsel, 0);
        chk("rst_wdat",   bus.wdat, 0);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready0", bus.req0_ready, 1);
        chk("post_rst_ready1", bus.req1_ready, 0);
        step();
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge CLK);
        chk("post_rst_wsel", bus.wsel, 5'd1);
        chk("post_rst_wdat", bus.wdat, 32'h1111_0001);

        // Single requester 1.
        step();
        bus.req1_valid = 1; bus.req1_wsel = 5'd5; bus.req1_wdat = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("single_ready1", bus.req1_ready, 1);
        step();
        bus.req1_valid = 0;
        @(negedge CLK);
        chk("single_wen",  bus.WEN, 1);
        chk("single_wsel", bus.wsel, 5'd5);
        chk("single_wdat", bus.wdat, 32'hDEAD_BEEF);
        chk("single_last", bus.last_grant, 1);

        // Contention: strict alternation starting with requester 0.
        step();
        bus.req0_valid = 1; bus.req0_wsel = 5'd6; bus.req0_wdat = 32'hA000_0000;
        bus.req1_valid = 1; bus.req1_wsel = 5'd7; bus.req1_wdat = 32'hB000_0000;
        prev = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k > 0) begin
                chk("cont_wen",  bus.WEN, 1);
                chk("cont_wdat", bus.wdat, prev);
            end
            chk("cont_ready0", bus.req0_ready, (k % 2 == 0));
            chk("cont_ready1", bus.req1_ready, (k % 2 == 1));
            prev = (k % 2 == 0) ? bus.req0_wdat : bus.req1_wdat;
            step();
            if (k % 2 == 0) bus.req0_wdat = bus.req0_wdat + 32'd1;
            else            bus.req1_wdat = bus.req1_wdat + 32'd1;
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge CLK);
        chk("cont_last_wen",  bus.WEN, 1);
        chk("cont_last_wdat", bus.wdat, 32'hB000_0002);

        // Write to $zero is consumed without enabling the register file.
        step();
        bus.req0_valid = 1; bus.req0_wsel = 5'd0; bus.req0_wdat = 32'h0000_1234;
        @(negedge CLK);
        chk("zero_ready0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 0; bus.rsel1 = 5'd0;
        @(negedge CLK);
        chk("zero_wen",  bus.WEN, 0);
        chk("zero_haz1", bus.haz1, 0);

        // Hazard on the pending write, gone once it has drained.
        step();
        bus.req0_valid = 1; bus.req0_wsel = 5'd9; bus.req0_wdat = 32'h0000_0099;
        step();
        bus.req0_valid = 0; bus.rsel1 = 5'd9; bus.rsel2 = 5'd3;
        @(negedge CLK);
        chk("haz_haz1", bus.haz1, 1);
        chk("haz_haz2", bus.haz2, 0);
        step();
        @(negedge CLK);
        chk("haz_clear", bus.haz1, 0);

        // Halt blocks grants; reset during release discards the would-be grant.
        step();
        bus.halt = 1;
        bus.req0_valid = 1; bus.req0_wsel = 5'd10; bus.req0_wdat = 32'hC0C0_0010;
        bus.req1_valid = 1; bus.req1_wsel = 5'd11; bus.req1_wdat = 32'hD0D0_0011;
        @(negedge CLK);
        chk("halt_ready0", bus.req0_ready, 0);
        chk("halt_ready1", bus.req1_ready, 0);
        step();
        @(negedge CLK);
        chk("halt_wen", bus.WEN, 0);
        step();
        bus.halt = 0; RST = 1'b1;
        @(negedge CLK);
        chk("midrst_ready0", bus.req0_ready, 0);
        chk("midrst_ready1", bus.req1_ready, 0);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_wen",    bus.WEN, 0);
        chk("midrst_ready0", bus.req0_ready, 1);
        chk("midrst_ready1", bus.req1_ready, 0);
        step();
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge CLK);
        chk("midrst_wsel", bus.wsel, 5'd10);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
